// File: rtl/usr_param.sv
// usr_param: parametrised universal shift register with hold, shift,
// rotate, arithmetic shift and parallel load, serial chaining outputs,
// and a counted burst-shift engine that reports through busy/done.
//
// Burst handshake: start is a single-cycle request. It is accepted only in
// IDLE with en high and a shift-class mode. On acceptance busy rises after
// that edge and stays high until the edge that performs the last step.
// done is then high for exactly one cycle. A request with cnt=0 never
// raises busy and yields a done pulse one cycle later. A start seen while
// busy is dropped rather than queued.
module usr_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             s_left,
  input  logic             s_right,
  input  logic [CNT_W-1:0] cnt,
  input  logic             start,
  output logic [WIDTH-1:0] Q,
  output logic             s_out_left,
  output logic             s_out_right,
  output logic             busy,
  output logic             done,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q_r, q_n;
  logic [2:0]       op_q, op_n;
  logic [CNT_W-1:0] rem_q, rem_n;
  logic             done_q, done_n;

  // One register step for a given operation code.
  function automatic logic [WIDTH-1:0] step_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] load,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    case (op)
      3'b001:  r = {sr, cur[WIDTH-1:1]};
      3'b010:  r = {cur[WIDTH-2:0], sl};
      3'b011:  r = load;
      3'b100:  r = {cur[0], cur[WIDTH-1:1]};
      3'b101:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b110:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: r = cur;
    endcase
    return r;
  endfunction

  // Modes that a burst may repeat; hold, load and reserved are excluded.
  function automatic logic is_shift_class(input logic [2:0] m);
    return (m == 3'b001) || (m == 3'b010) || (m == 3'b100) ||
           (m == 3'b101) || (m == 3'b110);
  endfunction

  // State register; reset wins over en and aborts a burst silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      q_r    <= '0;
      op_q   <= 3'b000;
      rem_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      q_r    <= q_n;
      op_q   <= op_n;
      rem_q  <= rem_n;
      done_q <= done_n;
    end
  end

  // Next-state logic: direct mode or burst acceptance in IDLE, counted
  // steps in BURST; en low freezes everything except the done pulse.
  always_comb begin
    state_n = state;
    q_n     = q_r;
    op_n    = op_q;
    rem_n   = rem_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          if (start && is_shift_class(mode)) begin
            if (cnt == '0) begin
              done_n = 1'b1;
            end else begin
              op_n    = mode;
              rem_n   = cnt;
              state_n = BURST;
            end
          end else begin
            q_n = step_op(mode, q_r, par_in, s_left, s_right);
          end
        end
      end
      BURST: begin
        if (en) begin
          q_n   = step_op(op_q, q_r, par_in, s_left, s_right);
          rem_n = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign Q           = q_r;
  assign s_out_left  = q_r[WIDTH-1];
  assign s_out_right = q_r[0];
  assign busy        = (state == BURST);
  assign done        = done_q;
  assign state_dbg   = state;

endmodule

// File: doc/usr_param.md
# usr_param

Parametrised universal shift register: the next generation of the team's 4-bit hold/shift/load register. It adds configurable width, rotate and arithmetic-shift modes, serial outputs for chaining, and a counted burst-shift engine with a busy/done handshake. It sits in datapath front-ends as a serialiser/deserialiser and as a barrel-shift substitute where one step per cycle is acceptable.

## Interface
- WIDTH, 8: register width in bits, ≥2.
- CNT_W, 4: width of the burst count port; burst length range is 0..2^CNT_W−1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  clock enable; low freezes Q and the burst counter.
- mode  in  3  operation select (see Operation).
- par_in  in  WIDTH  parallel load data.
- s_left  in  1  serial input for left shifts; enters at bit 0.
- s_right  in  1  serial input for right shifts; enters at bit WIDTH−1.
- cnt  in  CNT_W  burst step count, sampled with start.
- start  in  1  burst request, single-cycle pulse.
- Q  out  WIDTH  register contents.
- s_out_left  out  1  Q[WIDTH−1], combinational.
- s_out_right  out  1  Q[0], combinational.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse when a burst completes.

## Operation
- Mode encoding; one step per enabled edge:
  - 000: hold.
  - 001: shift right, Q ← {s_right, Q[W−1:1]}.
  - 010: shift left, Q ← {Q[W−2:0], s_left}.
  - 011: parallel load, Q ← par_in.
  - 100: rotate right, Q ← {Q[0], Q[W−1:1]}.
  - 101: rotate left, Q ← {Q[W−2:0], Q[W−1]}.
  - 110: arithmetic shift right, Q ← {Q[W−1], Q[W−1:1]}.
  - 111: reserved; behaves as hold.
- FSM has two states, IDLE and BURST.
- IDLE, start=0, en=1: apply the mode once per edge (direct mode).
- IDLE, start=1, en=1, mode ∈ {001, 010, 100, 101, 110}, cnt≠0:
  - Latch mode into op_q and cnt into rem_q; go to BURST.
  - Q is unchanged on this edge; start takes priority over direct mode.
- IDLE, start=1, cnt=0, shift-class mode: Q unchanged, stay IDLE, done=1 on the next cycle, busy never asserted.
- IDLE, start=1, mode ∈ {000, 011, 111}: start is ignored and the mode executes as direct.
- BURST, en=1:
  - Apply op_q once; s_left and s_right are sampled live at each step.
  - rem_q ← rem_q−1.
  - When rem_q reaches 0 on that edge: go to IDLE and set done=1 for one cycle.
- BURST, en=0: Q, rem_q, busy and state all hold (pause).
- BURST: mode, par_in, cnt and start are ignored; start while busy is dropped, not queued.
- cnt > WIDTH is legal. Rotates by WIDTH restore the original value. Shifts saturate naturally (all fill bits).
- rst_n=0 on any edge, including mid-burst:
  - Q=0, busy=0, done=0, rem_q=0, state=IDLE.
  - An aborted burst produces no done pulse.
  - Reset overrides en.

## Timing
- Direct-mode latency: 1 edge from sampling mode to Q update.
- Burst started at edge E0: shifts at E1..Ecnt (en high throughout).
  - busy is registered: high after E0, low after Ecnt.
  - done high for exactly the cycle after Ecnt.
- Each cycle with en low during a burst extends busy by one cycle.
- A new start is accepted in the same cycle done is high (state is IDLE).
- s_out_left/s_out_right follow Q combinationally, with no added latency.
- Reset values: Q=0, busy=0, done=0; s_out_* therefore 0.

## Test plan
All cases use WIDTH=8, CNT_W=4.
- Reset: load 8'hFF, hold rst_n=0 for one edge → Q=8'h00, busy=0, done=0; Q stays 0 with en=1, mode=000.
- Rotates: load 8'hA5 (mode 011), then mode 100 for one edge → Q=8'hD2; then mode 101 for one edge → Q=8'hA5.
- Shifts:
  - Q=8'h81, mode 010, s_left=1 → 8'h03.
  - Q=8'h90, mode 110 → 8'hC8.
  - Q=8'h90, mode 001, s_right=0 → 8'h48; s_out_right tracks Q[0].
- Burst: Q=8'h01, mode 101, cnt=3, start pulse → Q=8'h02, 8'h04, 8'h08 on the next three edges; busy high for 3 cycles; done high for 1 cycle after the last step; Q then holds.
- Pause and overlap:
  - Same burst with en=0 for 2 cycles after the first step → Q holds at 8'h02; busy lasts 5 cycles; final Q=8'h08.
  - start asserted while busy → ignored.
- Abort and zero count:
  - rst_n=0 after the 2nd step of a cnt=5 burst → Q=0, busy=0, no done pulse.
  - start with cnt=0 → Q unchanged, busy stays 0, done pulses once.
